// File: rtl/jtag_pkg.sv
// jtag_pkg: shared definitions for the parametrised JTAG TAP.
//   - tap_state_e : the 16 IEEE 1149.1 TAP controller states
//   - OP_*        : 4-bit instruction codes (zero-extended to IR_W by zext_code)
//   - IR_CAPTURE  : low bits loaded into the IR shift register in CAPTURE_IR
//   - bus_w       : width helper that never collapses to zero
package jtag_pkg;

  typedef enum logic [3:0] {
    ST_TEST_LOGIC_RESET,
    ST_RUN_TEST_IDLE,
    ST_SELECT_DR,
    ST_CAPTURE_DR,
    ST_SHIFT_DR,
    ST_EXIT1_DR,
    ST_PAUSE_DR,
    ST_EXIT2_DR,
    ST_UPDATE_DR,
    ST_SELECT_IR,
    ST_CAPTURE_IR,
    ST_SHIFT_IR,
    ST_EXIT1_IR,
    ST_PAUSE_IR,
    ST_EXIT2_IR,
    ST_UPDATE_IR
  } tap_state_e;

  localparam logic [3:0] OP_IDCODE         = 4'b1001;
  localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'b0101;
  localparam logic [3:0] OP_EXTEST         = 4'b0110;
  localparam logic [3:0] OP_INTEST         = 4'b0100;
  localparam logic [3:0] OP_CLAMP          = 4'b0010;
  localparam logic [3:0] OP_HIGHZ          = 4'b0011;
  localparam logic [3:0] USER_OPS [4]      = '{4'b1000, 4'b1010, 4'b1011, 4'b1100};

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  localparam int unsigned MAX_IR_W = 32;

  // Zero-extend a 4-bit opcode; callers truncate to their IR_W with a cast.
  function automatic logic [MAX_IR_W-1:0] zext_code(input logic [3:0] code);
    return {{(MAX_IR_W-4){1'b0}}, code};
  endfunction

  // Bus width of n fields of w bits, kept at least 1 so ports stay legal
  // when a configuration has no user registers.
  function automatic int unsigned bus_w(input int unsigned n, input int unsigned w);
    return (n * w == 0) ? 1 : n * w;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state IEEE 1149.1 TAP controller, clocked on TCK only.
//   TCK          in  test clock (state advances on rising edge)
//   TRSTn        in  asynchronous active-low reset to TEST_LOGIC_RESET
//   TMS          in  mode select
//   state        out current controller state
//   o_tlr        out in TEST_LOGIC_RESET
//   o_capture_dr / o_shift_dr / o_update_dr  out  DR-branch action states
//   o_capture_ir / o_shift_ir / o_update_ir  out  IR-branch action states
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRSTn,
  input  logic       TMS,
  output tap_state_e state,
  output logic       o_tlr,
  output logic       o_capture_dr,
  output logic       o_shift_dr,
  output logic       o_update_dr,
  output logic       o_capture_ir,
  output logic       o_shift_ir,
  output logic       o_update_ir
);

  tap_state_e r_state;
  tap_state_e w_next;

  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn) r_state <= ST_TEST_LOGIC_RESET;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_TEST_LOGIC_RESET: w_next = TMS ? ST_TEST_LOGIC_RESET : ST_RUN_TEST_IDLE;
      ST_RUN_TEST_IDLE:    w_next = TMS ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
      ST_SELECT_DR:        w_next = TMS ? ST_SELECT_IR        : ST_CAPTURE_DR;
      ST_CAPTURE_DR:       w_next = TMS ? ST_EXIT1_DR         : ST_SHIFT_DR;
      ST_SHIFT_DR:         w_next = TMS ? ST_EXIT1_DR         : ST_SHIFT_DR;
      ST_EXIT1_DR:         w_next = TMS ? ST_UPDATE_DR        : ST_PAUSE_DR;
      ST_PAUSE_DR:         w_next = TMS ? ST_EXIT2_DR         : ST_PAUSE_DR;
      ST_EXIT2_DR:         w_next = TMS ? ST_UPDATE_DR        : ST_SHIFT_DR;
      ST_UPDATE_DR:        w_next = TMS ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
      ST_SELECT_IR:        w_next = TMS ? ST_TEST_LOGIC_RESET : ST_CAPTURE_IR;
      ST_CAPTURE_IR:       w_next = TMS ? ST_EXIT1_IR         : ST_SHIFT_IR;
      ST_SHIFT_IR:         w_next = TMS ? ST_EXIT1_IR         : ST_SHIFT_IR;
      ST_EXIT1_IR:         w_next = TMS ? ST_UPDATE_IR        : ST_PAUSE_IR;
      ST_PAUSE_IR:         w_next = TMS ? ST_EXIT2_IR         : ST_PAUSE_IR;
      ST_EXIT2_IR:         w_next = TMS ? ST_UPDATE_IR        : ST_SHIFT_IR;
      ST_UPDATE_IR:        w_next = TMS ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
      default:             w_next = ST_TEST_LOGIC_RESET;
    endcase
  end

  always_comb begin
    o_tlr        = 1'b0;
    o_capture_dr = 1'b0;
    o_shift_dr   = 1'b0;
    o_update_dr  = 1'b0;
    o_capture_ir = 1'b0;
    o_shift_ir   = 1'b0;
    o_update_ir  = 1'b0;
    case (r_state)
      ST_TEST_LOGIC_RESET: o_tlr        = 1'b1;
      ST_CAPTURE_DR:       o_capture_dr = 1'b1;
      ST_SHIFT_DR:         o_shift_dr   = 1'b1;
      ST_UPDATE_DR:        o_update_dr  = 1'b1;
      ST_CAPTURE_IR:       o_capture_ir = 1'b1;
      ST_SHIFT_IR:         o_shift_ir   = 1'b1;
      ST_UPDATE_IR:        o_update_ir  = 1'b1;
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

// File: rtl/jtag_tap_param.sv
// jtag_tap_param: parametrised IEEE 1149.1 TAP with boundary scan,
// IDCODE, CLAMP/HIGHZ and up to four user data registers.
//   TCK, TRSTn, TMS, TDI   JTAG pins (TRSTn asynchronous active-low)
//   TDO, TDO_en            serial out and pad enable, updated on TCK falling edge
//   inputs / to_core       input pads and their (possibly overridden) core view
//   from_core / outputs    core outputs and their (possibly overridden) pad view
//   outputs_oe             output pad enable (low under HIGHZ)
//   user_capture           parallel capture data, register k at [k*USER_W +: USER_W]
//   user_dout              updated user data, same slicing
//   user_strobe            one-TCK pulse per user register after its update
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int unsigned IR_W        = 4,
  parameter int unsigned NUM_INPUTS  = 1,
  parameter int unsigned NUM_OUTPUTS = 1,
  parameter int unsigned NUM_USER    = 2,
  parameter int unsigned USER_W      = 8,
  parameter logic [31:0] DEVICE_ID   = {4'hF, 16'hED, 11'b00001001001, 1'b1}
) (
  input  logic                                  TCK,
  input  logic                                  TRSTn,
  input  logic                                  TMS,
  input  logic                                  TDI,
  output logic                                  TDO,
  output logic                                  TDO_en,
  input  logic [NUM_INPUTS-1:0]                 inputs,
  output logic [NUM_INPUTS-1:0]                 to_core,
  input  logic [NUM_OUTPUTS-1:0]                from_core,
  output logic [NUM_OUTPUTS-1:0]                outputs,
  output logic                                  outputs_oe,
  input  logic [bus_w(NUM_USER, USER_W)-1:0]    user_capture,
  output logic [bus_w(NUM_USER, USER_W)-1:0]    user_dout,
  output logic [bus_w(NUM_USER, 1)-1:0]         user_strobe
);

  localparam int unsigned BSR_W  = NUM_INPUTS + NUM_OUTPUTS;
  localparam int unsigned UBUS_W = bus_w(NUM_USER, USER_W);
  localparam int unsigned STB_W  = bus_w(NUM_USER, 1);

  localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(zext_code(OP_IDCODE));
  localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(zext_code(OP_SAMPLE_PRELOAD));
  localparam logic [IR_W-1:0] IR_EXTEST  = IR_W'(zext_code(OP_EXTEST));
  localparam logic [IR_W-1:0] IR_INTEST  = IR_W'(zext_code(OP_INTEST));
  localparam logic [IR_W-1:0] IR_CLAMP   = IR_W'(zext_code(OP_CLAMP));
  localparam logic [IR_W-1:0] IR_HIGHZ   = IR_W'(zext_code(OP_HIGHZ));
  localparam logic [IR_W-1:0] IR_CAP_VAL = IR_W'(IR_CAPTURE);

  // FSM decode
  tap_state_e w_state;
  logic       w_tlr, w_cap_dr, w_shift_dr, w_upd_dr, w_cap_ir, w_shift_ir, w_upd_ir;
  logic       w_ir_branch;

  // Registers
  logic [IR_W-1:0]   r_ir_shift;
  logic [IR_W-1:0]   r_ir_active;
  logic [BSR_W-1:0]  r_bsr;
  logic [BSR_W-1:0]  r_bsr_upd;
  logic [31:0]       r_id;
  logic [USER_W-1:0] r_usr;
  logic              r_byp;
  logic [UBUS_W-1:0] r_user_dout;
  logic [STB_W-1:0]  r_user_strobe;
  logic              r_tdo;
  logic              r_tdo_en;

  // Instruction decode
  logic [IR_W-1:0]   w_ir_eff;
  logic              w_is_sample, w_is_extest, w_is_intest, w_is_clamp, w_is_highz, w_is_idcode;
  logic              w_sel_bsr, w_user_hit;
  logic [1:0]        w_user_idx;
  logic [USER_W-1:0] w_user_cap;
  logic [USER_W:0]   w_usr_tmp;
  logic [USER_W-1:0] w_usr_shifted;
  logic              w_dr_lsb;
  logic              w_tdo_next;

  jtag_tap_fsm u_fsm (
    .TCK          (TCK),
    .TRSTn        (TRSTn),
    .TMS          (TMS),
    .state        (w_state),
    .o_tlr        (w_tlr),
    .o_capture_dr (w_cap_dr),
    .o_shift_dr   (w_shift_dr),
    .o_update_dr  (w_upd_dr),
    .o_capture_ir (w_cap_ir),
    .o_shift_ir   (w_shift_ir),
    .o_update_ir  (w_upd_ir)
  );

  always_comb begin
    w_ir_branch = w_state inside {ST_CAPTURE_IR, ST_SHIFT_IR, ST_EXIT1_IR,
                                  ST_PAUSE_IR, ST_EXIT2_IR, ST_UPDATE_IR};
  end

  // IDCODE is forced as soon as the FSM sits in TEST_LOGIC_RESET, so the
  // pad/core muxes release on the very edge that enters reset via TMS,
  // not one edge later when r_ir_active is reloaded.
  always_comb begin
    w_ir_eff    = w_tlr ? IR_IDCODE : r_ir_active;
    w_is_sample = (w_ir_eff == IR_SAMPLE);
    w_is_extest = (w_ir_eff == IR_EXTEST);
    w_is_intest = (w_ir_eff == IR_INTEST);
    w_is_clamp  = (w_ir_eff == IR_CLAMP);
    w_is_highz  = (w_ir_eff == IR_HIGHZ);
    w_is_idcode = (w_ir_eff == IR_IDCODE);
    w_sel_bsr   = w_is_sample | w_is_extest | w_is_intest;
    w_user_hit  = 1'b0;
    w_user_idx  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < NUM_USER && w_ir_eff == IR_W'(zext_code(USER_OPS[k]))) begin
        w_user_hit = 1'b1;
        w_user_idx = 2'(k);
      end
    end
  end

  always_comb begin
    w_user_cap = '0;
    for (int unsigned k = 0; k < NUM_USER; k++) begin
      if (w_user_idx == 2'(k)) w_user_cap = user_capture[k*USER_W +: USER_W];
    end
    // Works for USER_W == 1 as well as wider registers.
    w_usr_tmp     = {TDI, r_usr};
    w_usr_shifted = w_usr_tmp[USER_W:1];
  end

  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn) begin
      r_ir_shift    <= '0;
      r_ir_active   <= IR_IDCODE;
      r_bsr         <= '0;
      r_bsr_upd     <= '0;
      r_id          <= '0;
      r_usr         <= '0;
      r_byp         <= 1'b0;
      r_user_dout   <= '0;
      r_user_strobe <= '0;
    end else begin
      r_user_strobe <= '0;

      if (w_tlr)      r_ir_active <= IR_IDCODE;
      if (w_cap_ir)   r_ir_shift  <= IR_CAP_VAL;
      if (w_shift_ir) r_ir_shift  <= {TDI, r_ir_shift[IR_W-1:1]};
      if (w_upd_ir)   r_ir_active <= r_ir_shift;

      if (w_cap_dr) begin
        if (w_sel_bsr)   r_bsr <= {inputs, from_core};
        if (w_is_idcode) r_id  <= DEVICE_ID;
        if (w_user_hit)  r_usr <= w_user_cap;
        r_byp <= 1'b0;
      end

      if (w_shift_dr) begin
        if (w_sel_bsr)        r_bsr <= {TDI, r_bsr[BSR_W-1:1]};
        else if (w_is_idcode) r_id  <= {TDI, r_id[31:1]};
        else if (w_user_hit)  r_usr <= w_usr_shifted;
        else                  r_byp <= TDI;
      end

      if (w_upd_dr) begin
        if (w_sel_bsr) r_bsr_upd <= r_bsr;
        if (w_user_hit) begin
          for (int unsigned k = 0; k < NUM_USER; k++) begin
            if (w_user_idx == 2'(k)) begin
              r_user_dout[k*USER_W +: USER_W] <= r_usr;
              r_user_strobe[k]                <= 1'b1;
            end
          end
        end
      end
    end
  end

  // TDO source follows the FSM branch, so IR bits appear even if the
  // active instruction would select some data register.
  always_comb begin
    w_dr_lsb = r_byp;
    if (w_sel_bsr)        w_dr_lsb = r_bsr[0];
    else if (w_is_idcode) w_dr_lsb = r_id[0];
    else if (w_user_hit)  w_dr_lsb = r_usr[0];
    w_tdo_next = w_ir_branch ? r_ir_shift[0] : w_dr_lsb;
  end

  always_ff @(negedge TCK or negedge TRSTn) begin
    if (!TRSTn) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= w_tdo_next;
      r_tdo_en <= (w_state == ST_SHIFT_IR) || (w_state == ST_SHIFT_DR);
    end
  end

  assign TDO         = r_tdo;
  assign TDO_en      = r_tdo_en;
  assign to_core     = w_is_intest ? r_bsr_upd[BSR_W-1:NUM_OUTPUTS] : inputs;
  assign outputs     = (w_is_extest | w_is_intest | w_is_clamp) ? r_bsr_upd[NUM_OUTPUTS-1:0] : from_core;
  assign outputs_oe  = ~w_is_highz;
  assign user_dout   = r_user_dout;
  assign user_strobe = r_user_strobe;

endmodule

// File: tb/tb_jtag_tap_param.sv
module tb_jtag_tap_param;

  localparam int unsigned IR_W = 6;
  localparam int unsigned NI   = 2;
  localparam int unsigned NO   = 2;
  localparam int unsigned NU   = 2;
  localparam int unsigned UW   = 8;

  logic          TCK   = 1'b0;
  logic          TRSTn = 1'b0;
  logic          TMS   = 1'b1;
  logic          TDI   = 1'b0;
  logic          TDO, TDO_en;
  logic [NI-1:0] inputs;
  logic [NI-1:0] to_core;
  logic [NO-1:0] from_core;
  logic [NO-1:0] outputs;
  logic          outputs_oe;
  logic [NU*UW-1:0] user_capture;
  logic [NU*UW-1:0] user_dout;
  logic [NU-1:0]    user_strobe;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic tdo_s;
  logic en_s;
  logic [63:0] dout;

  always #5 TCK = ~TCK;

  jtag_tap_param #(
    .IR_W        (IR_W),
    .NUM_INPUTS  (NI),
    .NUM_OUTPUTS (NO),
    .NUM_USER    (NU),
    .USER_W      (UW)
  ) dut (
    .TCK          (TCK),
    .TRSTn        (TRSTn),
    .TMS          (TMS),
    .TDI          (TDI),
    .TDO          (TDO),
    .TDO_en       (TDO_en),
    .inputs       (inputs),
    .to_core      (to_core),
    .from_core    (from_core),
    .outputs      (outputs),
    .outputs_oe   (outputs_oe),
    .user_capture (user_capture),
    .user_dout    (user_dout),
    .user_strobe  (user_strobe)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One TCK cycle: sample TDO after the falling edge, then drive TMS/TDI
  // for the next rising edge and return 1 time unit after it.
  task automatic clk(input logic tms, input logic tdi);
    @(negedge TCK); #1;
    tdo_s = TDO;
    en_s  = TDO_en;
    TMS   = tms;
    TDI   = tdi;
    @(posedge TCK); #1;
  endtask

  // Shift n bits LSB first; the last bit is shifted with TMS=1 (-> EXIT1).
  task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dq);
    dq = '0;
    for (int i = 0; i < n; i++) begin
      clk((i == n - 1), din[i]);
      dq[i] = tdo_s;
    end
  endtask

  task automatic go_shift_dr();
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
  endtask

  task automatic finish_dr();
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
  endtask

  // From RUN_TEST_IDLE: load an instruction and return to RUN_TEST_IDLE.
  task automatic load_ir(input logic [63:0] code, output logic [63:0] cap);
    clk(1'b1, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    shift_bits(IR_W, code, cap);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    inputs       = 2'b01;
    from_core    = 2'b11;
    user_capture = 16'hA55A;

    // Reset state
    #2;
    check("rst_tdo",     TDO, 0);
    check("rst_tdo_en",  TDO_en, 0);
    check("rst_dout",    user_dout, 0);
    check("rst_strobe",  user_strobe, 0);
    check("rst_outputs", outputs, 2'b11);
    check("rst_to_core", to_core, 2'b01);
    check("rst_oe",      outputs_oe, 1);
    #10 TRSTn = 1'b1;

    // IDCODE read after reset
    clk(1'b0, 1'b0);
    go_shift_dr();
    shift_bits(32, 64'h0, dout);
    check("idcode", dout, 32'hF00ED093);
    check("idcode_en", en_s, 1);
    finish_dr();

    // IR capture pattern, then BYPASS
    load_ir(64'h3F, dout);
    check("ir_capture", dout, 6'b000001);
    go_shift_dr();
    shift_bits(8, 64'hB2, dout);
    check("bypass", dout, 8'h64);
    finish_dr();

    // SAMPLE_PRELOAD: capture {inputs,from_core}, preload 4'b1110
    load_ir(64'h05, dout);
    go_shift_dr();
    shift_bits(4, 64'hE, dout);
    check("sample_cap", dout, 4'h7);
    finish_dr();
    check("sample_outputs", outputs, 2'b11);

    // EXTEST drives preloaded output part
    load_ir(64'h06, dout);
    check("extest_outputs", outputs, 2'b10);
    check("extest_oe", outputs_oe, 1);

    // INTEST overrides core view of inputs
    load_ir(64'h04, dout);
    check("intest_to_core", to_core, 2'b11);
    check("intest_outputs", outputs, 2'b10);

    // HIGHZ
    load_ir(64'h03, dout);
    check("highz_oe", outputs_oe, 0);
    check("highz_outputs", outputs, 2'b11);
    check("highz_to_core", to_core, 2'b01);

    // CLAMP: outputs held, bypass DR
    load_ir(64'h02, dout);
    check("clamp_outputs", outputs, 2'b10);
    check("clamp_oe", outputs_oe, 1);
    go_shift_dr();
    shift_bits(2, 64'h3, dout);
    check("clamp_bypass", dout, 2'b10);
    finish_dr();

    // TMS reset from SHIFT_DR under EXTEST
    load_ir(64'h06, dout);
    from_core = 2'b01;
    go_shift_dr();
    for (int i = 0; i < 5; i++) clk(1'b1, 1'b0);
    check("tms_rst_outputs", outputs, 2'b01);
    check("tms_rst_tdo_en", TDO_en, 0);
    clk(1'b0, 1'b0);
    go_shift_dr();
    shift_bits(32, 64'h0, dout);
    check("tms_rst_idcode", dout, 32'hF00ED093);
    finish_dr();

    // TRSTn asserted mid-shift of USER0
    load_ir(64'h08, dout);
    go_shift_dr();
    for (int i = 0; i < 3; i++) clk(1'b0, 1'b1);
    check("trst_pre_en", en_s, 1);
    #2 TRSTn = 1'b0;
    #1;
    check("trst_en_async", TDO_en, 0);
    check("trst_strobe", user_strobe, 0);
    check("trst_dout", user_dout, 0);
    @(negedge TCK); #1;
    check("trst_en_negedge", TDO_en, 0);
    TRSTn = 1'b1;
    clk(1'b0, 1'b0);
    clk(1'b0, 1'b0);
    check("trst_post_strobe", user_strobe, 0);
    check("trst_post_dout", user_dout, 0);
    check("trst_outputs", outputs, 2'b01);
    check("trst_to_core", to_core, 2'b01);

    // USER1: capture A5, update 3C, single strobe
    load_ir(64'h0A, dout);
    go_shift_dr();
    shift_bits(8, 64'h3C, dout);
    check("user1_cap", dout, 8'hA5);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    check("user1_dout", user_dout, 16'h3C00);
    check("user1_strobe", user_strobe, 2'b10);
    clk(1'b0, 1'b0);
    check("user1_strobe_off", user_strobe, 2'b00);

    // USER3 with only two user registers behaves as BYPASS
    load_ir(64'h0C, dout);
    go_shift_dr();
    shift_bits(8, 64'hFF, dout);
    check("user3_bypass", dout, 8'hFE);
    finish_dr();
    check("user3_dout", user_dout, 16'h3C00);
    check("user3_strobe", user_strobe, 0);

    // USER0 shift split by PAUSE_DR, no recapture
    load_ir(64'h08, dout);
    go_shift_dr();
    shift_bits(4, 64'h6, dout);
    check("pause_lo", dout, 4'hA);
    clk(1'b0, 1'b0);
    clk(1'b1, 1'b0);
    clk(1'b0, 1'b0);
    shift_bits(4, 64'h9, dout);
    check("pause_hi", dout, 4'h5);
    finish_dr();
    check("pause_dout", user_dout, 16'h3C96);
    check("pause_strobe", user_strobe, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
